// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu
//  Purpose  : Load/store unit driving a word-organised data memory. Accepts
//             byte/half/word loads and stores, issues word-aligned addresses,
//             and performs sub-word stores as read-modify-write.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_lsu #(
    parameter int ADDR = 8,
    parameter int SIZE = 32     // datapath is fixed at 32 bits
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [ADDR-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            resp_valid,
    output logic [SIZE-1:0] resp_rdata,
    output logic            resp_err,
    output logic [ADDR-1:0] dmem_addr,
    output logic [SIZE-1:0] dmem_wdata,
    output logic            dmem_wen,
    input  logic [SIZE-1:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_signed;
    logic [1:0]      r_off;
    logic [SIZE-1:0] r_wdata;

    logic            r_req_ready;
    logic            r_resp_valid;
    logic [SIZE-1:0] r_resp_rdata;
    logic            r_resp_err;
    logic [ADDR-1:0] r_dmem_addr;
    logic [SIZE-1:0] r_dmem_wdata;
    logic            r_dmem_wen;

    logic            w_accept;
    logic            w_req_err;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [SIZE-1:0] w_load_data;
    logic [SIZE-1:0] w_merge_data;

    assign w_accept  = req_valid && r_req_ready;

    // Misalignment / illegal size detection on the incoming request
    assign w_req_err = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Select the addressed lane of the memory word and extend it for loads
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // Overlay the store data onto the captured word for sub-word stores
    always_comb begin
        w_merge_data = dmem_rdata;
        case (r_size)
            2'b00: begin
                case (r_off)
                    2'd0:    w_merge_data[7:0]   = r_wdata[7:0];
                    2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
                    2'd2:    w_merge_data[23:16] = r_wdata[7:0];
                    default: w_merge_data[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_off[1])
                    w_merge_data[31:16] = r_wdata[15:0];
                else
                    w_merge_data[15:0]  = r_wdata[15:0];
            end
            default: w_merge_data = r_wdata;
        endcase
    end

    // Control FSM with registered outputs; async reset drops any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_off        <= 2'b00;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wen   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_off       <= req_addr[1:0];
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (req_we && (req_size == 2'b10)) begin
                            // Full-word store needs no read of the old word
                            r_state      <= S_WRITE;
                            r_dmem_addr  <= {req_addr[ADDR-1:2], 2'b00};
                            r_dmem_wdata <= req_wdata;
                            r_dmem_wen   <= 1'b1;
                        end else begin
                            r_state     <= S_READ;
                            r_dmem_addr <= {req_addr[ADDR-1:2], 2'b00};
                        end
                    end
                end
                S_READ: begin
                    if (r_we) begin
                        r_state      <= S_WRITE;
                        r_dmem_wdata <= w_merge_data;
                        r_dmem_wen   <= 1'b1;
                    end else begin
                        r_state      <= S_RESP;
                        r_dmem_addr  <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_data;
                        r_resp_err   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_dmem_addr  <= '0;
                    r_dmem_wdata <= '0;
                    r_dmem_wen   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_wen   = r_dmem_wen;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_lsu
//  Purpose  : Directed self-checking bench for dmem_lsu with a word memory
//             model attached to the memory port.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_wen;
    logic [31:0] dmem_rdata;

    logic [31:0] mem [0:63];
    logic        load_mem;

    int n_cmp;
    int n_bad;

    dmem_lsu #(.ADDR(8), .SIZE(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wen   (dmem_wen),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge
    assign dmem_rdata = mem[dmem_addr[7:2]];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h8899AABB;   // byte 0x10
            mem[12] <= 32'h11223344;   // byte 0x30
        end else if (dmem_wen) begin
            mem[dmem_addr[7:2]] <= dmem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request (called just after a rising edge with the unit idle)
    // and observe 5 cycles after the handshake cycle N.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [7:0] addr, input logic [31:0] wd,
                           input int exp_resp_cyc, input int exp_wen_cyc,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic [31:0] exp_wdata);
        int          resp_cyc;
        int          wen_cnt;
        int          wen_at;
        logic [7:0]  wen_addr;
        logic [31:0] wen_data;
        logic [31:0] got_rdata;
        logic        got_err;
        resp_cyc = 0; wen_cnt = 0; wen_at = 0;
        wen_addr = 8'h0; wen_data = 32'h0; got_rdata = 32'h0; got_err = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (dmem_wen) begin
                wen_cnt++; wen_at = k; wen_addr = dmem_addr; wen_data = dmem_wdata;
            end
            if (resp_valid && resp_cyc == 0) begin
                resp_cyc = k; got_rdata = resp_rdata; got_err = resp_err;
            end
        end
        chk({tag, "_resp_cyc"}, resp_cyc, exp_resp_cyc);
        chk({tag, "_rdata"}, got_rdata, exp_rdata);
        chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        chk({tag, "_wen_cnt"}, wen_cnt, (exp_wen_cyc != 0) ? 1 : 0);
        chk({tag, "_wen_cyc"}, wen_at, exp_wen_cyc);
        if (exp_wen_cyc != 0) begin
            chk({tag, "_waddr"}, {24'd0, wen_addr}, {24'd0, addr[7:2], 2'b00});
            chk({tag, "_wdata"}, wen_data, exp_wdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int rv_cnt;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; load_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 8'h00; req_wdata = 32'h0;
        #2;
        chk("rst_ready_async", {31'd0, req_ready}, 32'd1);
        chk("rst_wen_async", {31'd0, dmem_wen}, 32'd0);
        repeat (2) @(posedge clk);
        #1 load_mem = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_daddr", {24'd0, dmem_addr}, 32'h0);
        chk("rst_dwdata", dmem_wdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Loads from preloaded 0x8899AABB at 0x10
        run_req("lw10",  1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 0, 32'h8899AABB, 1'b0, 32'h0);
        run_req("lb13",  1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 2, 0, 32'hFFFFFF88, 1'b0, 32'h0);
        run_req("lbu13", 1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 2, 0, 32'h00000088, 1'b0, 32'h0);
        run_req("lh12",  1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 2, 0, 32'hFFFF8899, 1'b0, 32'h0);
        run_req("lhu10", 1'b0, 2'b01, 1'b0, 8'h10, 32'h0, 2, 0, 32'h0000AABB, 1'b0, 32'h0);
        run_req("lbu11", 1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 2, 0, 32'h000000AA, 1'b0, 32'h0);
        run_req("lw_sgn", 1'b0, 2'b10, 1'b1, 8'h10, 32'h0, 2, 0, 32'h8899AABB, 1'b0, 32'h0);

        // Sub-word stores (read-modify-write)
        run_req("sb11",  1'b1, 2'b00, 1'b0, 8'h11, 32'h12345655, 3, 2, 32'h0, 1'b0, 32'h889955BB);
        run_req("lw10b", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 0, 32'h889955BB, 1'b0, 32'h0);
        run_req("sh32",  1'b1, 2'b01, 1'b0, 8'h32, 32'h9999CAFE, 3, 2, 32'h0, 1'b0, 32'hCAFE3344);
        chk("mem30", mem[12], 32'hCAFE3344);

        // Error cases
        run_req("e_sh11", 1'b1, 2'b01, 1'b0, 8'h11, 32'hFFFFFFFF, 1, 0, 32'h0, 1'b1, 32'h0);
        run_req("e_lw12", 1'b0, 2'b10, 1'b0, 8'h12, 32'h0, 1, 0, 32'h0, 1'b1, 32'h0);
        run_req("e_sz3",  1'b0, 2'b11, 1'b0, 8'h10, 32'h0, 1, 0, 32'h0, 1'b1, 32'h0);
        chk("mem10_err", mem[4], 32'h889955BB);

        // Word store with req_valid held, then LW accepted back-to-back
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 8'h20; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("b2b_ready_n", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        chk("b2b_ready_n1", {31'd0, req_ready}, 32'd0);
        chk("b2b_wen_n1", {31'd0, dmem_wen}, 32'd1);
        chk("b2b_wdata_n1", dmem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("b2b_ready_n2", {31'd0, req_ready}, 32'd0);
        chk("b2b_resp_n2", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        chk("b2b_ready_n3", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_lw_resp_n4", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("b2b_lw_resp_n5", {31'd0, resp_valid}, 32'd1);
        chk("b2b_lw_rdata", resp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset asserted during the WRITE cycle of a byte store
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 8'h10; req_wdata = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rw_wen_before", {31'd0, dmem_wen}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_wen_after", {31'd0, dmem_wen}, 32'd0);
        chk("rw_daddr_after", {24'd0, dmem_addr}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        rv_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        chk("rw_no_resp", rv_cnt, 0);
        chk("rw_ready", {31'd0, req_ready}, 32'd1);
        chk("rw_mem10", mem[4], 32'h889955BB);
        @(posedge clk); #1;
        run_req("post_rst_lw", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 0, 32'h889955BB, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that acts as the initiator side of the data-memory port. It sits between the CPU memory stage and the word-organised data memory. It accepts byte, halfword and word loads and stores over a valid/ready request interface and issues only word-aligned addresses to the memory. Sub-word stores are done as read-modify-write, because the memory supports whole-word writes only.

## Interface

- ADDR, 8, byte-address width of request and memory port
- SIZE, 32, data width (fixed at 32; other values unsupported)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and able to accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  ADDR  byte address
- req_wdata  input  SIZE  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  SIZE  load result; 0 for stores and errors
- resp_err  output  1  misaligned or illegal-size request; valid with resp_valid
- dmem_addr  output  ADDR  word-aligned byte address to memory
- dmem_wdata  output  SIZE  write data to memory
- dmem_wen  output  1  memory write enable
- dmem_rdata  input  SIZE  combinational read data from memory

## Operation

- States: IDLE, READ, WRITE, RESP.
- req_ready = (state == IDLE). A handshake occurs when req_valid && req_ready on a rising edge. The edge latches req_we, req_size, req_signed, req_addr and req_wdata.
- Alignment check at accept:
  - Error if size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11.
  - On error: go to RESP with resp_err=1. No memory access; dmem_wen stays 0.
- dmem_addr = {addr[ADDR-1:2], 2'b00} in READ and WRITE; 0 in IDLE and RESP.
- Transitions from IDLE after accept:
  - Load: IDLE → READ. READ captures dmem_rdata at the end-of-cycle edge, then → RESP.
  - Store word: IDLE → WRITE.
  - Store byte or half: IDLE → READ (capture old word) → WRITE.
  - WRITE → RESP. RESP → IDLE unconditionally.
- Byte lanes are little-endian; the lane is selected by addr[1:0]. Byte lanes: [7:0] at offset 0 through [31:24] at offset 3. Halfword lanes: [15:0] at offset 0, [31:16] at offset 2.
- Load result: the selected byte or half is extended to 32 bits. Sign extension if req_signed, else zero extension. Word loads ignore req_signed.
- Store merge:
  - Byte: the captured word with the selected byte replaced by wdata[7:0].
  - Half: the selected half replaced by wdata[15:0].
  - Word: wdata as-is. No READ cycle.
- dmem_wen = 1 only in WRITE, with dmem_wdata = merged word. dmem_wdata = 0 outside WRITE.
- resp_valid = 1 only in RESP. resp_rdata and resp_err are registered and valid only while resp_valid=1.
- req_valid asserted outside IDLE is ignored. No request queueing.

## Timing

- Cycle N is the cycle in which the handshake is sampled. resp_valid is high during:
  - N+1 for an error.
  - N+2 for a load.
  - N+2 for a word store; dmem_wen is high in N+1.
  - N+3 for a byte or half store; dmem_wen is high in N+2.
- Next accept is possible in the cycle after RESP. Throughput: one request per 2–4 cycles.
- The write commits on the rising edge that ends the WRITE cycle. Exactly one dmem_wen cycle per store; none for loads and errors.
- Reset values, applied immediately on rst assertion regardless of clk:
  - state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, dmem_addr 0, dmem_wdata 0, dmem_wen 0.
- Reset mid-operation: any in-flight request is dropped with no response.
  - If rst asserts during WRITE, dmem_wen falls before the next edge and memory is unchanged.
  - Operation resumes on the first edge after rst deasserts.

## Test plan

- Preload word 0x8899AABB at byte 0x10. LW 0x10 → resp_valid at N+2, resp_rdata 0x8899AABB, resp_err 0, dmem_wen never high.
- Same preload:
  - LB signed 0x13 → 0xFFFFFF88.
  - LBU 0x13 → 0x00000088.
  - LH signed 0x12 → 0xFFFF8899.
  - LHU 0x10 → 0x0000AABB.
- SB 0x11 with wdata 0x12345655 → dmem_wen only in N+2, dmem_addr 0x10, dmem_wdata 0x889955BB, resp_valid N+3. A following LW 0x10 returns 0x889955BB.
- SH 0x11, LW 0x12 and size 11 at 0x10 → resp_err 1 at N+1, resp_rdata 0, no dmem_wen, memory unchanged.
- SW 0x20 0xDEADBEEF with req_valid held high throughout → req_ready low for N+1..N+2, a second accept at N+3. LW 0x20 returns 0xDEADBEEF.
- SB 0x10 with rst pulsed during the WRITE cycle → dmem_wen drops within that cycle, no resp_valid, memory word unchanged, req_ready 1 after reset.
